// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-stage shift unit: op encodings,
// default datapath width and a helper to recognise encoded ops.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_op_t;

    // Codes above SH_ROR are unencoded and produce a zero result.
    function automatic logic op_known(input logic [2:0] op);
        return op <= SH_ROR;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One mux level of the barrel shifter: optionally moves the operand by a
// fixed distance DIST, left or right, with zero/sign fill or rotation.
module shift_level #(
    parameter int WIDTH = 32,
    parameter int DIST  = 16
) (
    input  logic             en,
    input  logic             left,
    input  logic             fill,
    input  logic             rotate,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result
);

    // Select the shifted form of the operand when this level is enabled.
    always_comb begin
        result = operand;
        if (en) begin
            if (left) begin
                result = {operand[WIDTH-DIST-1:0],
                          rotate ? operand[WIDTH-1:WIDTH-DIST] : {DIST{1'b0}}};
            end else begin
                result = {rotate ? operand[DIST-1:0] : {DIST{fill}},
                          operand[WIDTH-1:DIST]};
            end
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter for the execute stage. The SHAMT_W mux levels
// (largest distance first) are split across NB_STAGES register stages;
// op, word flag, shift amount and tag travel with the data.
//
// Handshake: an op transfers into the unit at a rising edge where
// valid_i && ready_o, and out of it where valid_o && ready_i. Stage k
// advances when it is empty or stage k+1 advances; the last stage advances
// on ready_i. ready_o depends only on stage valid bits and ready_i. While
// valid_o && !ready_i the output registers hold, so data_o/tag_o are stable.
// flush_i clears every stage valid bit and wins over a same-edge accept.
module shift_unit
    import riscv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int SHAMT_W   = $clog2(XLEN),
    parameter int NB_STAGES = 2,
    parameter int TAG_W     = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [2:0]         op_i,
    input  logic               word_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    data_o,
    output logic [TAG_W-1:0]   tag_o
);

    localparam int PER = (SHAMT_W + NB_STAGES - 1) / NB_STAGES;

    // Pipeline registers.
    logic [NB_STAGES-1:0] st_valid;
    logic [XLEN-1:0]      st_data  [NB_STAGES];
    logic [TAG_W-1:0]     st_tag   [NB_STAGES];
    logic [2:0]           st_op    [NB_STAGES];
    logic                 st_word  [NB_STAGES];
    logic [SHAMT_W-1:0]   st_shamt [NB_STAGES];

    // Combinational view of what feeds each stage register.
    logic [XLEN-1:0]      stage_in    [NB_STAGES];
    logic [XLEN-1:0]      stage_out   [NB_STAGES];
    logic [2:0]           stage_op    [NB_STAGES];
    logic                 stage_word  [NB_STAGES];
    logic [SHAMT_W-1:0]   stage_shamt [NB_STAGES];
    logic [TAG_W-1:0]     stage_tag   [NB_STAGES];

    logic [NB_STAGES-1:0] adv;
    logic [NB_STAGES-1:0] in_valid;

    logic                 word_eff;
    logic [XLEN-1:0]      operand;
    logic [SHAMT_W-1:0]   shamt_eff;
    logic [XLEN-1:0]      word_res;
    logic [XLEN-1:0]      result;

    // Word mode prepares the operand so the full-width levels give a
    // 32-bit result in the low half: rotates see the word duplicated,
    // SRA sees it sign-extended, logical shifts see it zero-extended.
    if (XLEN == 64) begin : g_w64
        assign word_eff  = word_i;
        assign shamt_eff = word_i ? {1'b0, shamt_i[4:0]} : shamt_i;
        assign word_res  = {{32{stage_out[NB_STAGES-1][31]}}, stage_out[NB_STAGES-1][31:0]};

        // Build the 64-bit operand for normal or word operation.
        always_comb begin
            operand = rs1_data_i;
            if (word_i) begin
                if (op_i == SH_ROL || op_i == SH_ROR)
                    operand = {rs1_data_i[31:0], rs1_data_i[31:0]};
                else if (op_i == SH_SRA)
                    operand = {{32{rs1_data_i[31]}}, rs1_data_i[31:0]};
                else
                    operand = {32'b0, rs1_data_i[31:0]};
            end
        end
    end else begin : g_w32
        logic unused_word;
        assign unused_word = word_i;
        assign word_eff    = 1'b0;
        assign shamt_eff   = shamt_i;
        assign operand     = rs1_data_i;
        assign word_res    = stage_out[NB_STAGES-1];
    end

    // Mux levels: level l moves by XLEN >> (l+1) and lives in stage l / PER.
    for (genvar l = 0; l < SHAMT_W; l++) begin : g_lvl
        localparam int K = l / PER;
        logic [XLEN-1:0] lin;
        logic [XLEN-1:0] lout;

        if (l % PER == 0) begin : g_first
            assign lin = stage_in[K];
        end else begin : g_next
            assign lin = g_lvl[l-1].lout;
        end

        shift_level #(.WIDTH(XLEN), .DIST(XLEN >> (l + 1))) u_level (
            .en      (stage_shamt[K][SHAMT_W-1-l]),
            .left    (stage_op[K] == SH_SLL || stage_op[K] == SH_ROL),
            .fill    (stage_op[K] == SH_SRA && lin[XLEN-1]),
            .rotate  (stage_op[K] == SH_ROL || stage_op[K] == SH_ROR),
            .operand (lin),
            .result  (lout)
        );
    end

    // Stage inputs come from the ports (stage 0) or the previous register;
    // a stage with no levels left simply re-registers its input.
    for (genvar k = 0; k < NB_STAGES; k++) begin : g_stage
        localparam int LO = k * PER;
        localparam int HI = (((k + 1) * PER < SHAMT_W) ? (k + 1) * PER : SHAMT_W) - 1;

        if (k == 0) begin : g_head
            assign stage_in[k]    = operand;
            assign stage_op[k]    = op_i;
            assign stage_word[k]  = word_eff;
            assign stage_shamt[k] = shamt_eff;
            assign stage_tag[k]   = tag_i;
        end else begin : g_body
            assign stage_in[k]    = st_data[k-1];
            assign stage_op[k]    = st_op[k-1];
            assign stage_word[k]  = st_word[k-1];
            assign stage_shamt[k] = st_shamt[k-1];
            assign stage_tag[k]   = st_tag[k-1];
        end

        if (LO < SHAMT_W) begin : g_levels
            assign stage_out[k] = g_lvl[HI].lout;
        end else begin : g_pass
            assign stage_out[k] = stage_in[k];
        end
    end

    // Final result: zero for unencoded ops, sign-extended word otherwise.
    always_comb begin
        result = stage_out[NB_STAGES-1];
        if (!op_known(stage_op[NB_STAGES-1]))
            result = '0;
        else if (stage_word[NB_STAGES-1])
            result = word_res;
    end

    // Advance chain from the output back to stage 0, plus stage feed valids.
    always_comb begin
        adv      = '0;
        in_valid = '0;
        adv[NB_STAGES-1] = !st_valid[NB_STAGES-1] || ready_i;
        for (int k = NB_STAGES - 2; k >= 0; k--)
            adv[k] = !st_valid[k] || adv[k+1];
        in_valid[0] = valid_i;
        for (int k = 1; k < NB_STAGES; k++)
            in_valid[k] = st_valid[k-1];
    end

    // Stage registers: valid moves on advance, payload loads only with a valid op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_valid <= '0;
            for (int k = 0; k < NB_STAGES; k++) begin
                st_data[k]  <= '0;
                st_tag[k]   <= '0;
                st_op[k]    <= '0;
                st_word[k]  <= 1'b0;
                st_shamt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NB_STAGES; k++) begin
                if (flush_i)
                    st_valid[k] <= 1'b0;
                else if (adv[k])
                    st_valid[k] <= in_valid[k];
                if (adv[k] && in_valid[k]) begin
                    st_data[k]  <= (k == NB_STAGES - 1) ? result : stage_out[k];
                    st_tag[k]   <= stage_tag[k];
                    st_op[k]    <= stage_op[k];
                    st_word[k]  <= stage_word[k];
                    st_shamt[k] <= stage_shamt[k];
                end
            end
        end
    end

    assign ready_o = adv[0];
    assign valid_o = st_valid[NB_STAGES-1];
    assign data_o  = st_data[NB_STAGES-1];
    assign tag_o   = st_tag[NB_STAGES-1];

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: a 32-bit/2-stage instance (a_*) and a
// 64-bit/4-stage instance (b_*), each with its own expected queue and
// output monitor.
module tb_shift_unit;
    import riscv_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT a: XLEN=32, NB_STAGES=2 ----------------
    logic        a_flush_i, a_valid_i, a_ready_o, a_word_i, a_valid_o, a_ready_i;
    logic [2:0]  a_op_i;
    logic [31:0] a_rs1, a_data_o;
    logic [4:0]  a_shamt, a_tag_i, a_tag_o;

    shift_unit #(.XLEN(32), .NB_STAGES(2), .TAG_W(5)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .flush_i(a_flush_i),
        .valid_i(a_valid_i), .ready_o(a_ready_o), .op_i(a_op_i), .word_i(a_word_i),
        .rs1_data_i(a_rs1), .shamt_i(a_shamt), .tag_i(a_tag_i),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .tag_o(a_tag_o)
    );

    // ---------------- DUT b: XLEN=64, NB_STAGES=4 ----------------
    logic        b_flush_i, b_valid_i, b_ready_o, b_word_i, b_valid_o, b_ready_i;
    logic [2:0]  b_op_i;
    logic [63:0] b_rs1, b_data_o;
    logic [5:0]  b_shamt;
    logic [4:0]  b_tag_i, b_tag_o;

    shift_unit #(.XLEN(64), .NB_STAGES(4), .TAG_W(5)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .flush_i(b_flush_i),
        .valid_i(b_valid_i), .ready_o(b_ready_o), .op_i(b_op_i), .word_i(b_word_i),
        .rs1_data_i(b_rs1), .shamt_i(b_shamt), .tag_i(b_tag_i),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .tag_o(b_tag_o)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q32[$];
    logic [68:0] exp_q64[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- driver tasks (call at a falling edge) ----------------
    task automatic issue32(input logic [2:0] op, input logic [31:0] x, input logic [4:0] s,
                           input logic [4:0] tag, input logic [31:0] exp, input bit push);
        bit acc = 1'b0;
        a_op_i = op; a_rs1 = x; a_shamt = s; a_tag_i = tag; a_valid_i = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            #1 acc = a_ready_o;
            @(posedge clk);
            if (acc && push) exp_q32.push_back({tag, exp});
            @(negedge clk);
        end
        a_valid_i = 1'b0;
        if (!acc) check("issue32_accept_timeout", 64'(a_ready_o), 64'd1);
    endtask

    task automatic issue64(input logic [2:0] op, input bit word, input logic [63:0] x,
                           input logic [5:0] s, input logic [4:0] tag,
                           input logic [63:0] exp, input bit push);
        bit acc = 1'b0;
        b_op_i = op; b_word_i = word; b_rs1 = x; b_shamt = s; b_tag_i = tag; b_valid_i = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            #1 acc = b_ready_o;
            @(posedge clk);
            if (acc && push) exp_q64.push_back({tag, exp});
            @(negedge clk);
        end
        b_valid_i = 1'b0;
        if (!acc) check("issue64_accept_timeout", 64'(b_ready_o), 64'd1);
    endtask

    // ---------------- monitors: pop on every output transfer ----------------
    bit          a_hold;
    logic [36:0] a_hold_val;
    bit          b_hold;
    logic [68:0] b_hold_val;

    // Output monitor for DUT a, sampled mid-low-phase when inputs are settled.
    always @(negedge clk) begin
        logic [36:0] e;
        #2;
        if (reset_n) begin
            if (a_hold && a_valid_o)
                check("stall32_stable", 64'({a_tag_o, a_data_o}), 64'(a_hold_val));
            a_hold     = a_valid_o && !a_ready_i;
            a_hold_val = {a_tag_o, a_data_o};
            if (a_valid_o && a_ready_i) begin
                if (exp_q32.size() == 0) begin
                    check("unexpected32_tag_data", 64'({a_tag_o, a_data_o}), 64'd0);
                end else begin
                    e = exp_q32.pop_front();
                    check("out32_tag", 64'(a_tag_o), 64'(e[36:32]));
                    check("out32_data", 64'(a_data_o), 64'(e[31:0]));
                end
            end
        end else begin
            a_hold = 1'b0;
        end
    end

    // Output monitor for DUT b.
    always @(negedge clk) begin
        logic [68:0] e;
        #2;
        if (reset_n) begin
            if (b_hold && b_valid_o) begin
                check("stall64_stable_data", b_data_o, b_hold_val[63:0]);
                check("stall64_stable_tag", 64'(b_tag_o), 64'(b_hold_val[68:64]));
            end
            b_hold     = b_valid_o && !b_ready_i;
            b_hold_val = {b_tag_o, b_data_o};
            if (b_valid_o && b_ready_i) begin
                if (exp_q64.size() == 0) begin
                    check("unexpected64_data", b_data_o, 64'd0);
                end else begin
                    e = exp_q64.pop_front();
                    check("out64_tag", 64'(b_tag_o), 64'(e[68:64]));
                    check("out64_data", b_data_o, e[63:0]);
                end
            end
        end else begin
            b_hold = 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        $display("FAIL watchdog_expired time=%0t required=finish", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        a_flush_i = 0; a_valid_i = 0; a_word_i = 0; a_op_i = 0; a_rs1 = 0; a_shamt = 0;
        a_tag_i = 0; a_ready_i = 1;
        b_flush_i = 0; b_valid_i = 0; b_word_i = 0; b_op_i = 0; b_rs1 = 0; b_shamt = 0;
        b_tag_i = 0; b_ready_i = 1;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst32_valid", 64'(a_valid_o), 64'd0);
        check("rst32_data",  64'(a_data_o),  64'd0);
        check("rst32_tag",   64'(a_tag_o),   64'd0);
        check("rst32_ready", 64'(a_ready_o), 64'd1);
        check("rst64_valid", 64'(b_valid_o), 64'd0);
        check("rst64_data",  b_data_o,       64'd0);
        check("rst64_ready", 64'(b_ready_o), 64'd1);

        // 32-bit: latency of two cycles on the first op
        @(negedge clk);
        issue32(SH_SRA, 32'h8000_0000, 5'd31, 5'd7, 32'hFFFF_FFFF, 1);
        #1 check("lat32_early", 64'(a_valid_o), 64'd0);
        @(negedge clk);
        #1 check("lat32_due", 64'(a_valid_o), 64'd1);
        @(negedge clk);

        // 32-bit directed vectors, back to back
        issue32(SH_SRL, 32'h8000_0000, 5'd31, 5'd7,  32'h0000_0001, 1);
        issue32(SH_ROR, 32'h0000_0001, 5'd1,  5'd2,  32'h8000_0000, 1);
        issue32(SH_ROL, 32'h8000_0001, 5'd4,  5'd3,  32'h0000_0018, 1);
        issue32(SH_SLL, 32'h1234_5678, 5'd0,  5'd4,  32'h1234_5678, 1);
        issue32(SH_SRA, 32'h7FFF_FFFF, 5'd4,  5'd5,  32'h07FF_FFFF, 1);
        issue32(SH_ROR, 32'h1234_5678, 5'd8,  5'd6,  32'h7812_3456, 1);
        issue32(SH_SLL, 32'h0000_0001, 5'd31, 5'd8,  32'h8000_0000, 1);
        issue32(3'd7,   32'hFFFF_FFFF, 5'd3,  5'd9,  32'h0000_0000, 1);
        issue32(3'd5,   32'hFFFF_FFFF, 5'd0,  5'd10, 32'h0000_0000, 1);
        issue32(SH_SRA, 32'hF0F0_F0F0, 5'd0,  5'd11, 32'hF0F0_F0F0, 1);
        issue32(SH_ROL, 32'h0000_FFFF, 5'd16, 5'd12, 32'hFFFF_0000, 1);
        issue32(SH_SRA, 32'h8000_0000, 5'd16, 5'd13, 32'hFFFF_8000, 1);
        issue32(SH_ROR, 32'h0000_00A5, 5'd4,  5'd14, 32'h5000_000A, 1);
        repeat (6) @(negedge clk);
        check("drain32_a", 64'(exp_q32.size()), 64'd0);

        // 32-bit backpressure: capacity two, third op waits
        a_ready_i = 1'b0;
        issue32(SH_SLL, 32'h0000_0001, 5'd1, 5'd1, 32'h0000_0002, 1);
        issue32(SH_SLL, 32'h0000_0001, 5'd2, 5'd2, 32'h0000_0004, 1);
        #1 check("bp_ready_low", 64'(a_ready_o), 64'd0);
        check("bp_valid_high", 64'(a_valid_o), 64'd1);
        @(negedge clk);
        fork
            issue32(SH_SLL, 32'h0000_0001, 5'd3, 5'd3, 32'h0000_0008, 1);
            begin
                repeat (3) @(negedge clk);
                a_ready_i = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        check("drain32_b", 64'(exp_q32.size()), 64'd0);

        // 64-bit: four-cycle latency, then word and full-width vectors
        issue64(SH_SLL, 1, 64'h0000_0000_4000_0000, 6'd1, 5'd1, 64'hFFFF_FFFF_8000_0000, 1);
        #1 cnt = 0;
        while (!b_valid_o && cnt < 10) begin
            @(negedge clk);
            #1 cnt++;
        end
        check("lat64_cycles_after_accept", 64'(cnt), 64'd3);
        @(negedge clk);
        issue64(SH_SRL, 1, 64'hFFFF_FFFF_8000_0000, 6'd33, 5'd2,  64'h0000_0000_4000_0000, 1);
        issue64(SH_SRA, 1, 64'h0000_0000_8000_0000, 6'd4,  5'd3,  64'hFFFF_FFFF_F800_0000, 1);
        issue64(SH_ROR, 1, 64'h0000_0000_0000_0001, 6'd1,  5'd4,  64'hFFFF_FFFF_8000_0000, 1);
        issue64(SH_ROL, 1, 64'hAAAA_AAAA_0000_0003, 6'd31, 5'd5,  64'hFFFF_FFFF_8000_0001, 1);
        issue64(SH_SRL, 1, 64'h1234_5678_9ABC_DEF0, 6'd0,  5'd6,  64'hFFFF_FFFF_9ABC_DEF0, 1);
        issue64(SH_SRA, 1, 64'h0000_0000_F000_0000, 6'd36, 5'd7,  64'hFFFF_FFFF_FF00_0000, 1);
        issue64(SH_ROL, 1, 64'hFFFF_FFFF_1234_5678, 6'd40, 5'd8,  64'h0000_0000_3456_7812, 1);
        issue64(SH_SRA, 0, 64'h8000_0000_0000_0000, 6'd63, 5'd9,  64'hFFFF_FFFF_FFFF_FFFF, 1);
        issue64(SH_ROR, 0, 64'h0000_0000_0000_0001, 6'd32, 5'd10, 64'h0000_0001_0000_0000, 1);
        issue64(SH_SLL, 0, 64'h0000_0000_FFFF_FFFF, 6'd32, 5'd11, 64'hFFFF_FFFF_0000_0000, 1);
        issue64(SH_SRL, 0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd60, 5'd12, 64'h0000_0000_0000_000F, 1);
        issue64(SH_ROL, 0, 64'h8000_0000_0000_0001, 6'd1,  5'd13, 64'h0000_0000_0000_0003, 1);
        issue64(3'd6,   0, 64'h0000_0000_0000_1234, 6'd0,  5'd14, 64'h0000_0000_0000_0000, 1);
        issue64(SH_SRA, 0, 64'h4000_0000_0000_0000, 6'd62, 5'd15, 64'h0000_0000_0000_0001, 1);
        repeat (8) @(negedge clk);
        check("drain64_a", 64'(exp_q64.size()), 64'd0);

        // 64-bit flush with two ops in flight and a new op on the same edge
        b_ready_i = 1'b0;
        issue64(SH_ROL, 0, 64'h0000_0000_0000_0001, 6'd1, 5'd20, 64'h2, 0);
        issue64(SH_ROL, 0, 64'h0000_0000_0000_0001, 6'd2, 5'd21, 64'h4, 0);
        repeat (2) @(negedge clk);
        #1 check("flush_pre_valid", 64'(b_valid_o), 64'd1);
        check("flush_pre_tag", 64'(b_tag_o), 64'd20);
        check("flush_pre_data", b_data_o, 64'h2);
        @(negedge clk);
        b_flush_i = 1'b1;
        b_valid_i = 1'b1; b_op_i = SH_SLL; b_word_i = 1'b0; b_rs1 = 64'h1; b_shamt = 6'd5; b_tag_i = 5'd22;
        #1 check("flush_ready_with_bubbles", 64'(b_ready_o), 64'd1);
        @(negedge clk);
        b_flush_i = 1'b0;
        b_valid_i = 1'b0;
        #1 check("flush_valid_cleared", 64'(b_valid_o), 64'd0);
        check("flush_ready_set", 64'(b_ready_o), 64'd1);
        @(negedge clk);
        b_ready_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1 if (b_valid_o) cnt++;
        end
        check("flush_dropped_ops_seen", 64'(cnt), 64'd0);
        @(negedge clk);

        // 32-bit async reset while an op is held at the output
        a_ready_i = 1'b0;
        issue32(SH_SLL, 32'h0000_0005, 5'd1, 5'd13, 32'h0000_000A, 0);
        @(negedge clk);
        #1 check("arst_pre_valid", 64'(a_valid_o), 64'd1);
        check("arst_pre_data", 64'(a_data_o), 64'h0000_000A);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(a_valid_o), 64'd0);
        check("arst_data",  64'(a_data_o),  64'd0);
        check("arst_tag",   64'(a_tag_o),   64'd0);
        check("arst_ready", 64'(a_ready_o), 64'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        a_ready_i = 1'b1;
        repeat (3) @(negedge clk);

        check("final_q32_empty", 64'(exp_q32.size()), 64'd0);
        check("final_q64_empty", 64'(exp_q64.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
Parametrised, pipelined barrel shifter for the execute stage. It supersedes the single-cycle combinational 32-bit shifter.
- Supports XLEN 32/64, logical and arithmetic shifts, rotates, and RV64 word (W) variants.
- Register stages are configurable; a valid/ready handshake with backpressure and flush is provided.
- Sits between the issue logic and the writeback mux, alongside the ALU.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
SHAMT_W, $clog2(XLEN), shift-amount width; derived, do not override.
NB_STAGES, 2, pipeline register stages; legal range 1..SHAMT_W.
TAG_W, 5, width of the sideband tag (destination register index).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
flush_i  input  1  synchronous kill of all in-flight operations.
valid_i  input  1  operation presented.
ready_o  output  1  unit can accept an operation this cycle.
op_i  input  3  shift_op_t: SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR.
word_i  input  1  W variant; legal only when XLEN=64.
rs1_data_i  input  XLEN  operand.
shamt_i  input  SHAMT_W  shift amount; only the low bits are used.
tag_i  input  TAG_W  sideband, passed through unchanged.
valid_o  output  1  result available.
ready_i  input  1  consumer accepts the result.
data_o  output  XLEN  result.
tag_o  output  TAG_W  tag of the result.

Behaviour:
- Reset: all stage valid bits, data, tag and op registers clear to 0 asynchronously. Hence valid_o=0, data_o=0, tag_o=0, ready_o=1 on release.
- Mux levels: SHAMT_W levels with distances XLEN/2 down to 1, largest first.
- Level-to-stage mapping:
  - Levels are split across stages in order, ceil(SHAMT_W/NB_STAGES) levels per stage; the last stage takes the remainder.
  - Each stage ends in a register. Stage 0 logic is fed directly from the inputs.
- Latency: exactly NB_STAGES cycles from accept (valid_i&ready_o at an edge) to valid_o, with no backpressure. Throughput is 1 op/cycle.
- Handshake:
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when ready_i=1.
  - Bubbles collapse.
  - ready_o = stage-0 advance condition, purely combinational from the valid bits and ready_i. There is no combinational path from valid_i.
  - Capacity is NB_STAGES ops; no op is lost or reordered.
  - While valid_o=1 and ready_i=0, data_o and tag_o hold stable.
- Shift semantics, with s = shamt_i as used and x = operand:
  - SLL: x<<s, zero fill.
  - SRL: x>>s, zero fill.
  - SRA: x>>s, fill with x[MSB].
  - ROL: (x<<s)|(x>>(W-s)).
  - ROR: (x>>s)|(x<<(W-s)).
  - s=0 is a passthrough for all ops.
- Word mode (XLEN=64, word_i=1):
  - The operand is rs1[31:0] and W=32. s = shamt_i[4:0]; shamt_i[5] is ignored.
  - SRA fill comes from bit 31.
  - The 32-bit result is sign-extended from bit 31 into data_o[63:32].
  - When XLEN=32, word_i is ignored.
- Unencoded op_i values produce data_o=0, and the op still completes with valid_o and tag_o.
- flush_i=1 at an edge clears all stage valid bits, taking priority over accepts on the same edge. valid_o=0 the following cycle and ready_o=1.
- reset_n asserted mid-operation: outputs go to reset values immediately, without waiting for clk.
- Op and word_i travel with the data through each stage, so mixed ops in flight are independent.

Decomposition:
- riscv_pkg: shift_op_t enum (3-bit), SH_* encodings, XLEN default.
- Sub-module shift_level:
  - Parameters WIDTH and DIST; combinational.
  - Performs one conditional distance-DIST shift with enable bit, direction, fill bit and rotate select.
  - Instantiated SHAMT_W times via generate.
- All pipeline registers live in shift_unit.

Test Plan:
1. XLEN=32, NB_STAGES=2: SH_SRA x=0x80000000 s=31 tag=7, ready_i=1 -> two cycles later valid_o=1, data_o=0xFFFFFFFF, tag_o=7. SH_SRL with the same inputs -> 0x00000001.
2. SH_ROR x=0x00000001 s=1 -> 0x80000000. SH_ROL x=0x80000001 s=4 -> 0x00000018. SH_SLL x=0x12345678 s=0 -> 0x12345678.
3. Backpressure: hold ready_i=0, issue three back-to-back ops (tags 1,2,3):
   - ready_o drops after two accepts; tag 3 is held.
   - Raise ready_i -> tags 1,2,3 emerge in order, one per cycle.
   - data_o stays stable while stalled.
4. XLEN=64, word mode:
   - SH_SLL x=0x0000000040000000 s=1 -> 0xFFFFFFFF80000000.
   - SH_SRL x=0xFFFFFFFF80000000 s=33 (effective 1) -> 0x0000000040000000.
   - SH_SRA word x=0x0000000080000000 s=4 -> 0xFFFFFFFFF8000000.
5. Assert flush_i with two ops in flight and valid_i=1 on the same edge -> valid_o=0 next cycle and the new op is dropped. Async reset_n low mid-flight -> valid_o=0, data_o=0 before the next clk edge.
6. Sweep NB_STAGES=1..SHAMT_W with random ops/amounts against a reference model -> latency equals NB_STAGES and all results match.
